// File: rtl/aes_pkg.sv
// Shared AES widths and the MixColumns sequencer FSM encoding.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_NCOL    = 4;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/mix_col.sv
// Combinational AES MixColumns on one 32-bit column, first byte in the MSBs.
module mix_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] b  [4];
  logic [7:0] m2 [4];
  logic [7:0] m3 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign b[i] = col_i[31-8*i -: 8];
    mul u_mul (
      .a_i  (b[i]),
      .x2_o (m2[i]),
      .x3_o (m3[i])
    );
  end

  // Fixed circulant matrix {02 03 01 01} applied row by row
  assign col_o = {m2[0] ^ m3[1] ^ b[2]  ^ b[3],
                  b[0]  ^ m2[1] ^ m3[2] ^ b[3],
                  b[0]  ^ b[1]  ^ m2[2] ^ m3[3],
                  m3[0] ^ b[1]  ^ b[2]  ^ m2[3]};

endmodule

// File: rtl/mul.sv
// GF(2^8) constant multiplier: returns a*{02} and a*{03} modulo the AES polynomial.
module mul (
  input  logic [7:0] a_i,
  output logic [7:0] x2_o,
  output logic [7:0] x3_o
);

  assign x2_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? 8'h1b : 8'h00);
  assign x3_o = x2_o ^ a_i;

endmodule

// File: rtl/mix_col_seq.sv
// MixColumns over a full AES state, one column per cycle through a shared mix_col,
// with valid/ready on both sides and a bypass for the final round.
module mix_col_seq
  import aes_pkg::*;
#(
  parameter int unsigned NCOL = AES_NCOL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [1:0] COL_LAST = 2'(NCOL - 1);

  mc_state_e   state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [127:0] src_q, src_d;
  logic [127:0] res_q, res_d;
  logic [31:0] mix_in;
  logic [31:0] mix_out;

  // Column mux from the captured source state
  always_comb begin
    mix_in = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (col_q == 2'(c)) begin
        mix_in = src_q[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
      end
    end
  end

  mix_col u_mix_col (
    .col_i (mix_in),
    .col_o (mix_out)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    src_d   = src_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_bypass) begin
            res_d   = in_state;
            state_d = DONE;
          end else begin
            src_d   = in_state;
            col_d   = 2'd0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        for (int unsigned c = 0; c < NCOL; c++) begin
          if (col_q == 2'(c)) begin
            res_d[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] = mix_out;
          end
        end
        col_d = col_q + 2'd1;
        if (col_q == COL_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  // Handshake flags decode straight from the state register
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign out_state = res_q;

endmodule

// File: tb/tb_mix_col_seq.sv
// Directed bench for mix_col_seq: known vectors, bypass, backpressure, back-to-back, reset.
module tb_mix_col_seq;

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_c6c6c6c6_01010101_db135345;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_c6c6c6c6_01010101_8e4da1bc;
  localparam logic [127:0] VC6    = {4{32'hc6c6c6c6}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mix_col_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_st(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle accept from IDLE
  task automatic accept(input logic [127:0] s, input logic byp);
    chk_b("accept_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
    tick();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
  endtask

  // Cycles from accept until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc[$];
    logic [127:0] r1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_bypass = 1'b0;
    out_ready = 1'b1;

    // Reset values before any clock edge
    #2;
    chk_b ("rst_in_ready",  in_ready,  1'b1);
    chk_b ("rst_out_valid", out_valid, 1'b0);
    chk_b ("rst_busy",      busy,      1'b0);
    chk_st("rst_out_state", out_state, '0);
    #10;
    rst_n = 1'b1;
    tick();

    // Known vector, mix path
    accept(V1_IN, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk_b("v1_in_ready_run", in_ready, 1'b0);
      tick();
      lat++;
    end
    chk_n ("v1_latency",       lat,       4);
    chk_b ("v1_in_ready_done", in_ready,  1'b0);
    chk_b ("v1_busy_done",     busy,      1'b1);
    chk_st("v1_out_state",     out_state, V1_OUT);
    tick();
    chk_b("v1_idle_ready", in_ready,  1'b1);
    chk_b("v1_idle_valid", out_valid, 1'b0);
    chk_b("v1_idle_busy",  busy,      1'b0);

    // Bypass: state passes unmixed after one cycle
    accept(V1_IN, 1'b1);
    chk_b ("byp_valid", out_valid, 1'b1);
    chk_st("byp_state", out_state, V1_IN);
    chk_b ("byp_busy",  busy,      1'b1);
    tick();
    chk_b("byp_idle", in_ready, 1'b1);

    // Backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    accept(V2_IN, 1'b0);
    wait_valid(lat);
    chk_n("bp_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid  = (i == 5);
      in_state  = (i == 5) ? VC6 : V2_IN;
      in_bypass = (i == 5);
      chk_st("bp_state_hold", out_state, V2_OUT);
      chk_b ("bp_valid_hold", out_valid, 1'b1);
      chk_b ("bp_in_ready",   in_ready,  1'b0);
      tick();
    end
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    chk_st("bp_state_after", out_state, V2_OUT);
    out_ready = 1'b1;
    tick();
    chk_b("bp_idle_ready", in_ready,  1'b1);
    chk_b("bp_idle_valid", out_valid, 1'b0);
    tick();
    chk_b("bp_pulse_ignored", busy, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    r1        = '0;
    in_state  = V1_IN;
    in_valid  = 1'b1;
    in_bypass = 1'b0;
    for (int c = 0; c < 40 && acc.size() < 2; c++) begin
      if (in_ready) acc.push_back(c);
      if (out_valid) r1 = out_state;
      tick();
      if (acc.size() == 1) in_state = VC6;
    end
    in_valid = 1'b0;
    chk_st("b2b_first_result", r1, V1_OUT);
    chk_n ("b2b_accepts", acc.size(), 2);
    if (acc.size() == 2) chk_n("b2b_interval", acc[1] - acc[0], 6);
    wait_valid(lat);
    chk_n ("b2b_latency", lat, 4);
    chk_st("b2b_second_result", out_state, VC6);
    tick();

    // Async reset during RUN column 2
    accept(V1_IN, 1'b0);
    tick();
    tick();
    chk_b ("mid_busy_before", busy, 1'b1);
    chk_b ("mid_state_nonzero", (out_state != '0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk_b ("mid_rst_valid",    out_valid, 1'b0);
    chk_b ("mid_rst_busy",     busy,      1'b0);
    chk_st("mid_rst_state",    out_state, '0);
    chk_b ("mid_rst_in_ready", in_ready,  1'b1);
    #3;
    rst_n = 1'b1;
    tick();
    chk_b("post_rst_ready", in_ready, 1'b1);
    accept(V2_IN, 1'b0);
    wait_valid(lat);
    chk_n ("post_rst_latency", lat, 4);
    chk_st("post_rst_state",   out_state, V2_OUT);
    tick();
    chk_b("post_rst_idle", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
